// File: rtl/mod_arith_pkg.sv
// ----------------------------------------------------------------------------
// mod_arith_pkg
//
// Shared definitions for the digit-serial modular arithmetic blocks.
//
// Contents:
//   state_t        - FSM encoding shared by the serial modular adder
//   DEF_W / DEF_D  - default operand width and digit width
//   calcDigits     - number of D-bit digits in a W-bit operand (W / D)
//   calcIdxW       - width of a digit index counter, never less than 1 bit
// ----------------------------------------------------------------------------
package mod_arith_pkg;

    // Operation sequencing: accept, first pass (a + b), second pass
    // (s - p), then present the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_W = 256;
    localparam int DEF_D = 64;

    // Number of digits processed per pass.
    function automatic int calcDigits(input int w, input int d);
        return w / d;
    endfunction

    // Index width; a single-digit configuration still needs a 1-bit counter
    // so the index register stays a legal vector.
    function automatic int calcIdxW(input int n);
        int lw;
        lw = $clog2(n);
        return (lw < 1) ? 1 : lw;
    endfunction

endpackage : mod_arith_pkg

// File: rtl/mod_add_serial_digit_adder.sv
// ----------------------------------------------------------------------------
// digit_adder
//
// Plain D-bit add-with-carry primitive: {cout, sum} = x + y + cin.
// Purely combinational; the caller owns the carry register.
//
// Ports:
//   x    in  D  first digit operand
//   y    in  D  second digit operand
//   cin  in  1  carry in
//   sum  out D  low D bits of the digit sum
//   cout out 1  carry out (bit D of the digit sum)
// ----------------------------------------------------------------------------
module digit_adder #(
    parameter int D = 64
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         cin,
    output logic [D-1:0] sum,
    output logic         cout
);

    logic [D:0] w_full;

    // Every operand is widened to D+1 bits so the carry out lands in the
    // top bit of the sum.
    assign w_full = {1'b0, x} + {1'b0, y} + {{D{1'b0}}, cin};
    assign sum    = w_full[D-1:0];
    assign cout   = w_full[D];

endmodule : digit_adder

// File: rtl/mod_add_serial.sv
// ----------------------------------------------------------------------------
// mod_add_serial
//
// Digit-serial modular adder: result = (a + b) mod p. One D-bit digit adder
// is reused over N = W/D cycles per pass. Pass one forms s = a + b (keeping
// the final carry cadd), pass two forms t = s + ~p + 1 (final carry csub),
// and a final select cycle registers t when either carry is set, else s.
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst        in  1  asynchronous active-high reset
//   in_valid   in  1  a, b, p valid
//   in_ready   out 1  block accepts operands (IDLE only, low during reset)
//   a, b       in  W  addends
//   p          in  W  modulus
//   out_valid  out 1  result valid, held until out_ready
//   out_ready  in  1  consumer accepts result
//   result     out W  (a + b) mod p
//   busy       out 1  high in every state except IDLE
// ----------------------------------------------------------------------------
module mod_add_serial
    import mod_arith_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         busy
);

    localparam int N    = calcDigits(W, D);
    localparam int IDXW = calcIdxW(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t            r_state;
    state_t            w_nextState;

    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cadd;
    logic              r_csub;
    logic              r_subLast;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_p;
    logic [W-1:0]      r_s;
    logic [W-1:0]      r_t;
    logic [W-1:0]      r_result;

    logic [D-1:0]      w_x;
    logic [D-1:0]      w_y;
    logic [D-1:0]      w_sum;
    logic              w_cout;
    logic              w_lastDigit;

    assign w_lastDigit = (r_idx == LAST_IDX);

    // Operand muxes in front of the single shared digit adder: (a, b) in the
    // first pass, (s, ~p) in the second. Inverting p and seeding the carry
    // with 1 turns the adder into a subtractor.
    always_comb begin
        w_x = r_a[r_idx*D +: D];
        w_y = r_b[r_idx*D +: D];
        if (r_state == SUB) begin
            w_x = r_s[r_idx*D +: D];
            w_y = ~r_p[r_idx*D +: D];
        end
    end

    digit_adder #(
        .D (D)
    ) u_digitAdder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. SUB spends N digit cycles plus one select cycle,
    // which r_subLast marks.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid)    w_nextState = ADD;
            ADD:  if (w_lastDigit) w_nextState = SUB;
            SUB:  if (r_subLast)   w_nextState = DONE;
            DONE: if (out_ready)   w_nextState = IDLE;
            default:               w_nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, per-digit s/t updates, carry chaining
    // through the carry register and the final select into the result.
    // The result register is only written in the select cycle, so it stays
    // stable through DONE and IDLE until the next operation finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_cadd    <= 1'b0;
            r_csub    <= 1'b0;
            r_subLast <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_s       <= '0;
            r_t       <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_p       <= p;
                        r_carry   <= 1'b0;
                        r_idx     <= '0;
                        r_subLast <= 1'b0;
                    end
                end
                ADD: begin
                    r_s[r_idx*D +: D] <= w_sum;
                    if (w_lastDigit) begin
                        r_cadd  <= w_cout;
                        r_carry <= 1'b1;
                        r_idx   <= '0;
                    end else begin
                        r_carry <= w_cout;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                SUB: begin
                    if (r_subLast) begin
                        // cadd means a + b overflowed W bits, so the sum is
                        // certainly >= p; csub means s >= p within W bits.
                        r_result  <= (r_cadd | r_csub) ? r_t : r_s;
                        r_subLast <= 1'b0;
                    end else begin
                        r_t[r_idx*D +: D] <= w_sum;
                        r_carry           <= w_cout;
                        if (w_lastDigit) begin
                            r_csub    <= w_cout;
                            r_subLast <= 1'b1;
                            r_idx     <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // in_ready is gated by rst so the block never advertises readiness
    // while it is being held in reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule : mod_add_serial

// File: tb/tb_mod_add_serial.sv
// ----------------------------------------------------------------------------
// tb_mod_add_serial
//
// Scoreboard bench for mod_add_serial: a W=256/D=64 instance for the main
// cases and a W=64/D=16 instance for the post-reset small-width case.
// ----------------------------------------------------------------------------
module tb_mod_add_serial;

    logic         clk;
    logic         rst;

    logic         inValid;
    logic         inReady;
    logic [255:0] opA;
    logic [255:0] opB;
    logic [255:0] opP;
    logic         outValid;
    logic         outReady;
    logic [255:0] result;
    logic         busy;

    logic         sInValid;
    logic         sInReady;
    logic [63:0]  sA;
    logic [63:0]  sB;
    logic [63:0]  sP;
    logic         sOutValid;
    logic         sOutReady;
    logic [63:0]  sResult;
    logic         sBusy;

    logic [255:0] expQ[$];
    logic [63:0]  sExpQ[$];

    int checkCount;
    int errorCount;

    mod_add_serial #(
        .W (256),
        .D (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .p         (opP),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (result),
        .busy      (busy)
    );

    mod_add_serial #(
        .W (64),
        .D (16)
    ) dutSmall (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sInValid),
        .in_ready  (sInReady),
        .a         (sA),
        .b         (sB),
        .p         (sP),
        .out_valid (sOutValid),
        .out_ready (sOutReady),
        .result    (sResult),
        .busy      (sBusy)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: (a + b) mod p for a, b < p, using a 257-bit sum.
    function automatic logic [255:0] modAdd(input logic [255:0] x, input logic [255:0] y,
                                            input logic [255:0] m);
        logic [256:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
        return sum[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full operation on the wide instance, starting #1 after a rising
    // edge: drive and score the operands, check latency, check the result,
    // hold out_ready low for holdCycles, then complete the transfer.
    task automatic applyStimulus(input logic [255:0] xa, input logic [255:0] xb,
                                 input logic [255:0] xp, input int holdCycles,
                                 input int expLatency);
        int guard;
        int lat;
        logic [255:0] held;
        logic [255:0] expected;

        guard = 0;
        while (!inReady && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("inReadyBeforeOp", inReady, 1);

        inValid = 1'b1;
        opA = xa;
        opB = xb;
        opP = xp;
        expQ.push_back(modAdd(xa, xb, xp));
        @(posedge clk); #1;

        // Scramble operands while busy; the latched copy must be used.
        inValid = 1'b0;
        opA = ~xa;
        opB = ~xb;
        opP = ~xp;
        checkOutput("busyAfterAccept", busy, 1);

        lat = 0;
        while (!outValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("outValidSeen", outValid, 1);
        if (expLatency > 0) checkOutput("latency", lat, expLatency);

        if (expQ.size() > 0) expected = expQ.pop_front();
        else expected = '0;
        checkOutput("result", result, expected);
        held = result;

        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk); #1;
            checkOutput("holdOutValid", outValid, 1);
            checkOutput("holdResult", result, held);
            checkOutput("holdInReady", inReady, 0);
        end

        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("outValidAfterXfer", outValid, 0);
        checkOutput("inReadyAfterXfer", inReady, 1);
        checkOutput("resultAfterXfer", result, held);
    endtask

    initial begin
        logic [255:0] p25519;
        logic [255:0] p189;
        logic [255:0] ra;
        logic [255:0] rb;
        int guard;
        int lat;
        logic [63:0] sExp;

        checkCount = 0;
        errorCount = 0;
        p25519 = (256'd1 << 255) - 256'd19;
        p189   = 256'd0 - 256'd189;

        rst       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b0;
        opA       = '0;
        opB       = '0;
        opP       = '0;
        sInValid  = 1'b0;
        sOutReady = 1'b0;
        sA        = '0;
        sB        = '0;
        sP        = '0;

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady", inReady, 0);
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstResult", result, 0);
        rst = 1'b0;
        #1;
        checkOutput("releaseInReady", inReady, 1);
        @(posedge clk); #1;

        // Directed cases.
        applyStimulus(256'd3, 256'd4, p25519, 0, 9);
        applyStimulus(p25519 - 1, 256'd2, p25519, 0, 9);
        applyStimulus(p189 - 1, p189 - 1, p189, 0, 9);
        applyStimulus((256'd1 << 64) - 1, 256'd1, p189, 0, 9);

        // Backpressure followed by back-to-back operations.
        ra = rand256() >> 2;
        rb = rand256() >> 2;
        applyStimulus(ra, rb, p25519, 5, 9);
        ra = p189 - (rand256() >> 4);
        rb = p189 - (rand256() >> 4);
        applyStimulus(ra, rb, p189, 0, 9);
        ra = rand256() >> 1;
        rb = rand256() >> 1;
        applyStimulus(ra, rb, p25519, 2, 9);

        // Reset in the middle of SUB: no push, the operation is discarded.
        inValid = 1'b1;
        opA = 256'd11;
        opB = 256'd22;
        opP = p25519;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("busyMidSub", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstOutValid", outValid, 0);
        checkOutput("midRstResult", result, 0);
        checkOutput("midRstInReady", inReady, 0);
        checkOutput("midRstBusy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("rstHeldOutValid", outValid, 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", inReady, 1);
        checkOutput("postRstSmallInReady", sInReady, 1);
        @(posedge clk); #1;
        checkOutput("postRstNoPulse", outValid, 0);

        // Small-width instance: 5 + 6 mod 7.
        sInValid = 1'b1;
        sA = 64'd5;
        sB = 64'd6;
        sP = 64'd7;
        sExp = modAdd(256'd5, 256'd6, 256'd7);
        sExpQ.push_back(sExp);
        @(posedge clk); #1;
        sInValid = 1'b0;
        lat = 0;
        while (!sOutValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("smallOutValidSeen", sOutValid, 1);
        checkOutput("smallLatency", lat, 9);
        if (sExpQ.size() > 0) sExp = sExpQ.pop_front();
        else sExp = '0;
        checkOutput("smallResult", sResult, sExp);
        sOutReady = 1'b1;
        @(posedge clk); #1;
        sOutReady = 1'b0;
        checkOutput("smallInReadyAfterXfer", sInReady, 1);

        // A fresh wide operation after reset as well.
        guard = 0;
        while (!inReady && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        applyStimulus(256'd100, p25519 - 50, p25519, 0, 9);

        checkOutput("scoreboardEmpty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_mod_add_serial
